// File: rtl/axi_rr_arb_onehot_if.sv
// Arbiter request/grant bundle: request vector and burst marker in, one downstream channel and grants out.
// Latency: none, wires only.
// Backpressure: ready_i comes from downstream; valid_o/gnt_o carry the offer back.
interface axi_rr_arb_onehot_if #(
    parameter int N_REQ     = 8,
    parameter int IDX_WIDTH = $clog2(N_REQ)
);
    logic [N_REQ-1:0]     req_i;
    logic                 last_i;
    logic                 ready_i;
    logic                 valid_o;
    logic [IDX_WIDTH-1:0] idx_o;
    logic [N_REQ-1:0]     gnt_o;

    // Arbiter side.
    modport slave (
        input  req_i,
        input  last_i,
        input  ready_i,
        output valid_o,
        output idx_o,
        output gnt_o
    );

    // Requesters plus downstream channel.
    modport master (
        output req_i,
        output last_i,
        output ready_i,
        input  valid_o,
        input  idx_o,
        input  gnt_o
    );
endinterface

// File: rtl/axi_rr_arb_onehot.sv
// Round-robin arbiter: N requesters onto one valid/ready channel, binary index plus one-hot grant.
// Latency: zero cycles from req_i to valid_o/idx_o/gnt_o; state updates on the handshake edge.
// Backpressure: an unaccepted offer is held (HOLD) and a locked burst (BURST) pins the index until last_i.
module axi_rr_arb_onehot #(
    parameter int N_REQ     = 8,
    parameter int IDX_WIDTH = $clog2(N_REQ),
    parameter int LOCK_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_rr_arb_onehot_if.slave   arb
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t               state_q;
    logic [IDX_WIDTH-1:0] rr_q;
    logic [IDX_WIDTH-1:0] sel_q;

    logic                 search_hit;
    logic [IDX_WIDTH-1:0] search_idx;
    logic                 valid;
    logic [IDX_WIDTH-1:0] idx;
    logic                 hs;
    logic [N_REQ-1:0]     gnt;

    // Modulo-N add; both operands stay below N_REQ so one subtraction is enough.
    function automatic logic [IDX_WIDTH-1:0] wrap_idx(input logic [IDX_WIDTH-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IDX_WIDTH'(s);
    endfunction

    // Pointer advance that wraps at N_REQ-1, never landing on an unused code.
    function automatic logic [IDX_WIDTH-1:0] next_ptr(input logic [IDX_WIDTH-1:0] cur);
        return (cur == IDX_WIDTH'(N_REQ - 1)) ? '0 : cur + 1'b1;
    endfunction

    // First set request scanning upward from the priority pointer.
    always_comb begin
        search_hit = 1'b0;
        search_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!search_hit && arb.req_i[wrap_idx(rr_q, k)]) begin
                search_hit = 1'b1;
                search_idx = wrap_idx(rr_q, k);
            end
        end
    end

    // Offer toward downstream: live search when idle, held index otherwise; silenced during reset.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        case (state_q)
            IDLE: begin
                valid = search_hit;
                idx   = search_idx;
            end
            HOLD: begin
                valid = 1'b1;
                idx   = sel_q;
            end
            BURST: begin
                valid = arb.req_i[sel_q];
                idx   = sel_q;
            end
            default: begin
                valid = 1'b0;
                idx   = '0;
            end
        endcase
        if (!rst_n) begin
            valid = 1'b0;
        end
    end

    assign hs = valid & arb.ready_i;

    // Grant only the accepted winner, so the vector is one-hot or zero.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = hs && (idx == IDX_WIDTH'(i));
        end
    end

    assign arb.valid_o = valid;
    assign arb.idx_o   = idx;
    assign arb.gnt_o   = gnt;

    // Hold/burst state machine and priority pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (hs) begin
                        if ((LOCK_EN != 0) && !arb.last_i) begin
                            state_q <= BURST;
                            sel_q   <= idx;
                        end else begin
                            state_q <= IDLE;
                            rr_q    <= next_ptr(idx);
                        end
                    end else if (valid) begin
                        state_q <= HOLD;
                        sel_q   <= idx;
                    end
                end
                BURST: begin
                    if (hs && arb.last_i) begin
                        state_q <= IDLE;
                        rr_q    <= next_ptr(sel_q);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rr_arb_onehot.sv
// Bench for axi_rr_arb_onehot: 8-way locked instance and 5-way unlocked instance.
// Latency: outputs compared 2 time units after each rising edge against a queue-free spec model.
// Backpressure: ready_i driven directly, random phase toggles it freely.
module tb_axi_rr_arb_onehot;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_rr_arb_onehot_if #(.N_REQ(8)) if8 ();
    axi_rr_arb_onehot_if #(.N_REQ(5)) if5 ();

    axi_rr_arb_onehot #(.N_REQ(8), .LOCK_EN(1)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (if8.slave)
    );

    axi_rr_arb_onehot #(.N_REQ(5), .LOCK_EN(0)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (if5.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model per instance: 0 = free arbitration, 1 = offer pending, 2 = locked burst.
    int m_mode [2];
    int m_ptr  [2];
    int m_sel  [2];

    function automatic int n_of(input int inst);
        return (inst == 0) ? 8 : 5;
    endfunction

    function automatic int lock_of(input int inst);
        return (inst == 0) ? 1 : 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_ptr[i]  = 0;
            m_sel[i]  = 0;
        end
    endfunction

    function automatic void model_out(input int inst, input logic [7:0] req, input logic rdy,
                                      input logic rst, output logic v, output int idx,
                                      output logic [7:0] g);
        int n;
        int cand;
        n   = n_of(inst);
        v   = 1'b0;
        idx = 0;
        if (m_mode[inst] == 0) begin
            for (int k = 0; k < n; k++) begin
                cand = (m_ptr[inst] + k) % n;
                if (!v && req[3'(cand)]) begin
                    v   = 1'b1;
                    idx = cand;
                end
            end
        end else if (m_mode[inst] == 1) begin
            v   = 1'b1;
            idx = m_sel[inst];
        end else begin
            v   = req[3'(m_sel[inst])];
            idx = m_sel[inst];
        end
        if (!rst) v = 1'b0;
        g = (v && rdy) ? 8'(1 << idx) : 8'h00;
    endfunction

    function automatic void model_step(input int inst, input logic [7:0] req, input logic rdy,
                                       input logic last);
        logic       v;
        int         idx;
        logic [7:0] g;
        model_out(inst, req, rdy, 1'b1, v, idx, g);
        if (m_mode[inst] != 2) begin
            if (v && rdy) begin
                if (lock_of(inst) != 0 && !last) begin
                    m_mode[inst] = 2;
                    m_sel[inst]  = idx;
                end else begin
                    m_mode[inst] = 0;
                    m_ptr[inst]  = (idx + 1) % n_of(inst);
                end
            end else if (v) begin
                m_mode[inst] = 1;
                m_sel[inst]  = idx;
            end
        end else if (v && rdy && last) begin
            m_mode[inst] = 0;
            m_ptr[inst]  = (m_sel[inst] + 1) % n_of(inst);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive8(input logic [7:0] req, input logic rdy, input logic last);
        if8.req_i   = req;
        if8.ready_i = rdy;
        if8.last_i  = last;
    endtask

    task automatic drive5(input logic [4:0] req, input logic rdy, input logic last);
        if5.req_i   = req;
        if5.ready_i = rdy;
        if5.last_i  = last;
    endtask

    // One clock: compare both DUTs with the model (plus optional directed values), then advance.
    task automatic step(input string tag, input int which, input logic dv, input int didx,
                        input logic [7:0] dg);
        logic       v;
        int         ix;
        logic [7:0] g;
        #1;
        if (!rst_n) model_reset();
        model_out(0, if8.req_i, if8.ready_i, rst_n, v, ix, g);
        chk({tag, "/m8_vld"}, 32'(if8.valid_o), 32'(v));
        chk({tag, "/m8_idx"}, 32'(if8.idx_o), 32'(ix));
        chk({tag, "/m8_gnt"}, 32'(if8.gnt_o), 32'(g));
        model_out(1, {3'b000, if5.req_i}, if5.ready_i, rst_n, v, ix, g);
        chk({tag, "/m5_vld"}, 32'(if5.valid_o), 32'(v));
        chk({tag, "/m5_idx"}, 32'(if5.idx_o), 32'(ix));
        chk({tag, "/m5_gnt"}, 32'(if5.gnt_o), 32'(g));
        if (which == 8) begin
            chk({tag, "/d8_vld"}, 32'(if8.valid_o), 32'(dv));
            chk({tag, "/d8_idx"}, 32'(if8.idx_o), 32'(didx));
            chk({tag, "/d8_gnt"}, 32'(if8.gnt_o), 32'(dg));
        end else if (which == 5) begin
            chk({tag, "/d5_vld"}, 32'(if5.valid_o), 32'(dv));
            chk({tag, "/d5_idx"}, 32'(if5.idx_o), 32'(didx));
            chk({tag, "/d5_gnt"}, 32'(if5.gnt_o), 32'({3'b000, if5.gnt_o} === dg ? dg : dg));
        end
        @(posedge clk);
        if (rst_n) begin
            model_step(0, if8.req_i, if8.ready_i, if8.last_i);
            model_step(1, {3'b000, if5.req_i}, if5.ready_i, if5.last_i);
        end else begin
            model_reset();
        end
        #1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        drive8(8'hFF, 1'b1, 1'b1);
        drive5(5'h00, 1'b0, 1'b0);
        #1;

        // Reset with every request raised: nothing offered, nothing granted.
        step("reset_a", 8, 1'b0, 0, 8'h00);
        step("reset_b", 8, 1'b0, 0, 8'h00);
        rst_n = 1'b1;

        // Full request vector: winner rotates through every index and wraps.
        for (int k = 0; k < 10; k++) begin
            step("rr_fair", 8, 1'b1, k % 8, 8'(1 << (k % 8)));
        end

        // Unaccepted offer on index 2 stays put, even after req moves to index 1.
        drive8(8'h04, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step("hold_wait", 8, 1'b1, 2, 8'h00);
        end
        drive8(8'h02, 1'b1, 1'b1);
        step("hold_accept", 8, 1'b1, 2, 8'h04);
        step("hold_next", 8, 1'b1, 1, 8'h02);

        // Reset pulse so the burst starts from a known pointer.
        rst_n = 1'b0;
        step("rst_pulse", 8, 1'b0, 1, 8'h00);
        rst_n = 1'b1;

        // Four-beat burst on index 0 with index 3 waiting; a gap pauses it.
        drive8(8'h09, 1'b1, 1'b0);
        step("burst_b1", 8, 1'b1, 0, 8'h01);
        step("burst_b2", 8, 1'b1, 0, 8'h01);
        drive8(8'h08, 1'b1, 1'b0);
        step("burst_gap", 8, 1'b0, 0, 8'h00);
        drive8(8'h09, 1'b1, 1'b0);
        step("burst_b3", 8, 1'b1, 0, 8'h01);
        drive8(8'h09, 1'b1, 1'b1);
        step("burst_b4", 8, 1'b1, 0, 8'h01);
        step("burst_after", 8, 1'b1, 3, 8'h08);

        // Async reset between beats 2 and 3 of a burst.
        drive8(8'h09, 1'b1, 1'b0);
        step("rb_b1", 8, 1'b1, 0, 8'h01);
        step("rb_b2", 8, 1'b1, 0, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("rb_async_vld", 32'(if8.valid_o), 32'(1'b0));
        chk("rb_async_gnt", 32'(if8.gnt_o), 32'h0);
        step("rb_held", 8, 1'b0, 0, 8'h00);
        rst_n = 1'b1;
        drive8(8'hFF, 1'b1, 1'b1);
        step("rb_restart0", 8, 1'b1, 0, 8'h01);
        step("rb_restart1", 8, 1'b1, 1, 8'h02);
        drive8(8'h00, 1'b0, 1'b0);

        // Five requesters: wrap from index 4 back to 0; last_i has no effect without locking.
        drive5(5'b10001, 1'b1, 1'b1);
        step("wrap5_a", 5, 1'b1, 0, 8'h01);
        step("wrap5_b", 5, 1'b1, 4, 8'h10);
        drive5(5'b10001, 1'b1, 1'b0);
        step("wrap5_c", 5, 1'b1, 0, 8'h01);
        step("wrap5_d", 5, 1'b1, 4, 8'h10);

        // Five requesters: held offer survives its own request dropping.
        drive5(5'b00110, 1'b0, 1'b0);
        step("hold5_wait", 5, 1'b1, 1, 8'h00);
        drive5(5'b00100, 1'b1, 1'b0);
        step("hold5_accept", 5, 1'b1, 1, 8'h02);
        step("hold5_next", 5, 1'b1, 2, 8'h04);

        // Random traffic on both instances with occasional resets.
        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            drive8(8'($urandom & $urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            drive5(5'($urandom & $urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 0);
            step("rand", 0, 1'b0, 0, 8'h00);
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
